instr_decode_queue: RTL and testbench

//  Parametrised instruction front-end for the TPU: buffers incoming instructions in a FIFO,

---
 rtl/instr_decode_queue.sv | 203 ++++++++++++++++++++
 tb/tb_instr_decode_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_queue.sv
// Instruction FIFO with an opcode decoder and a single-entry issue stage on a valid/ready handshake.
// Optional statistics counters are enabled by defining DECODE_STATS_EN.
module instr_decode_queue #(
  parameter int DIM_W       = 7,
  parameter int ADDR_W      = 12,
  parameter int QUEUE_DEPTH = 4,
  localparam int INSTR_W    = 4 + 3*DIM_W + 2*ADDR_W,
  localparam int CNT_W      = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic [INSTR_W-1:0] instruction_i,
  output logic               issue_valid_o,
  input  logic               issue_ready_i,
  output logic [2:0]         MAC_op_o,
  output logic [DIM_W-1:0]   V_dim_o,
  output logic [DIM_W-1:0]   U_dim_o,
  output logic [DIM_W-1:0]   ITER_dim_o,
  output logic [DIM_W-1:0]   V_dim1_o,
  output logic [DIM_W-1:0]   U_dim1_o,
  output logic [DIM_W-1:0]   ITER_dim1_o,
  output logic [ADDR_W-1:0]  ub_addr_rd_o,
  output logic [ADDR_W-1:0]  ub_addr_wr_o,
  output logic               illegal_op_o,
  output logic [CNT_W-1:0]   queue_count_o,
  output logic [15:0]        issued_cnt_o,
  output logic [15:0]        illegal_cnt_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  typedef enum logic { ST_EMPTY = 1'b0, ST_HOLD = 1'b1 } state_t;

  state_t state_reg, state_next;

  logic [INSTR_W-1:0] mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               ready_en_reg;
  logic               illegal_reg;
  logic               full, empty, push, pop, handshake, load;

  assign full          = (count_reg == CNT_W'(QUEUE_DEPTH));
  assign empty         = (count_reg == '0);
  assign instr_ready_o = ready_en_reg && !full;
  assign push          = instr_valid_i && instr_ready_o;
  assign handshake     = (state_reg == ST_HOLD) && issue_ready_i;
  assign pop           = !empty && ((state_reg == ST_EMPTY) || handshake);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= instruction_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head-of-queue decode
  logic [INSTR_W-1:0] head;
  logic [3:0]         head_op;
  logic [DIM_W-1:0]   head_v, head_u, head_it;
  logic [ADDR_W-1:0]  head_rd, head_wr;

  assign head    = mem[rd_ptr_reg];
  assign head_op = head[3:0];
  assign head_v  = head[4 +: DIM_W];
  assign head_u  = head[4 + DIM_W +: DIM_W];
  assign head_it = head[4 + 2*DIM_W +: DIM_W];
  assign head_rd = head[4 + 3*DIM_W +: ADDR_W];
  assign head_wr = head[4 + 3*DIM_W + ADDR_W +: ADDR_W];

  logic              dec_issuable, dec_illegal, dims_nz;
  logic [2:0]        dec_mac;
  logic [DIM_W-1:0]  dec_v, dec_u, dec_it, dec_v1, dec_u1, dec_it1;
  logic [ADDR_W-1:0] dec_rd, dec_wr;

  assign dims_nz = (head_v != '0) && (head_u != '0) && (head_it != '0);

  always_comb begin
    dec_issuable = 1'b0;
    dec_illegal  = 1'b0;
    dec_mac      = 3'b000;
    dec_v        = '0;
    dec_u        = '0;
    dec_it       = '0;
    dec_v1       = '0;
    dec_u1       = '0;
    dec_it1      = '0;
    dec_rd       = head_rd;
    dec_wr       = head_wr;
    case (head_op)
      4'h0: ;
      4'h1, 4'h2: begin
        // A zero dimension would underflow the minus-one outputs, so it is rejected.
        if (dims_nz) begin
          dec_issuable = 1'b1;
          dec_mac      = (head_op == 4'h1) ? 3'b010 : 3'b001;
          dec_v        = head_v;
          dec_u        = head_u;
          dec_it       = head_it;
          dec_v1       = head_v - 1'b1;
          dec_u1       = head_u - 1'b1;
          dec_it1      = head_it - 1'b1;
          if (head_op == 4'h2) dec_wr = '0;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      4'h3: begin
        dec_issuable = 1'b1;
        dec_mac      = 3'b100;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    if (pop && dec_issuable) begin
      state_next = ST_HOLD;
      load       = 1'b1;
    end else if (handshake) begin
      state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= ST_EMPTY;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      MAC_op_o     <= '0;
      V_dim_o      <= '0;
      U_dim_o      <= '0;
      ITER_dim_o   <= '0;
      V_dim1_o     <= '0;
      U_dim1_o     <= '0;
      ITER_dim1_o  <= '0;
      ub_addr_rd_o <= '0;
      ub_addr_wr_o <= '0;
      illegal_reg  <= 1'b0;
    end else begin
      illegal_reg <= pop && dec_illegal;
      if (load) begin
        MAC_op_o     <= dec_mac;
        V_dim_o      <= dec_v;
        U_dim_o      <= dec_u;
        ITER_dim_o   <= dec_it;
        V_dim1_o     <= dec_v1;
        U_dim1_o     <= dec_u1;
        ITER_dim1_o  <= dec_it1;
        ub_addr_rd_o <= dec_rd;
        ub_addr_wr_o <= dec_wr;
      end
    end
  end

  assign issue_valid_o = (state_reg == ST_HOLD);
  assign illegal_op_o  = illegal_reg;
  assign queue_count_o = count_reg;

`ifdef DECODE_STATS_EN
  logic [15:0] issued_cnt_reg, illegal_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issued_cnt_reg  <= '0;
      illegal_cnt_reg <= '0;
    end else begin
      if (handshake && issued_cnt_reg != 16'hFFFF)
        issued_cnt_reg <= issued_cnt_reg + 1'b1;
      if (pop && dec_illegal && illegal_cnt_reg != 16'hFFFF)
        illegal_cnt_reg <= illegal_cnt_reg + 1'b1;
    end
  end

  assign issued_cnt_o  = issued_cnt_reg;
  assign illegal_cnt_o = illegal_cnt_reg;
`else
  assign issued_cnt_o  = 16'h0000;
  assign illegal_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: a decode vector table plus hand-written
// back-pressure, illegal, bubble, reset and statistics sequences.
module tb_instr_decode_queue;

  localparam int DIM_W   = 7;
  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 4 + 3*DIM_W + 2*ADDR_W;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               instr_valid_i = 1'b0;
  logic               instr_ready_o;
  logic [INSTR_W-1:0] instruction_i = '0;
  logic               issue_valid_o;
  logic               issue_ready_i = 1'b0;
  logic [2:0]         MAC_op_o;
  logic [DIM_W-1:0]   V_dim_o, U_dim_o, ITER_dim_o, V_dim1_o, U_dim1_o, ITER_dim1_o;
  logic [ADDR_W-1:0]  ub_addr_rd_o, ub_addr_wr_o;
  logic               illegal_op_o;
  logic [2:0]         queue_count_o;
  logic [15:0]        issued_cnt_o, illegal_cnt_o;

  instr_decode_queue dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instruction_i(instruction_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .MAC_op_o(MAC_op_o),
    .V_dim_o(V_dim_o), .U_dim_o(U_dim_o), .ITER_dim_o(ITER_dim_o),
    .V_dim1_o(V_dim1_o), .U_dim1_o(U_dim1_o), .ITER_dim1_o(ITER_dim1_o),
    .ub_addr_rd_o(ub_addr_rd_o), .ub_addr_wr_o(ub_addr_wr_o),
    .illegal_op_o(illegal_op_o), .queue_count_o(queue_count_o),
    .issued_cnt_o(issued_cnt_o), .illegal_cnt_o(illegal_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int n_issued = 0;
  int n_illegal = 0;

  typedef struct {
    logic [3:0]        op;
    logic [DIM_W-1:0]  v, u, it;
    logic [ADDR_W-1:0] rd, wr;
    logic              exp_issue, exp_ill;
    logic [2:0]        mac;
    logic [DIM_W-1:0]  ev, eu, ei, ev1, eu1, ei1;
    logic [ADDR_W-1:0] erd, ewr;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [INSTR_W-1:0] pack(input logic [3:0] op, input logic [DIM_W-1:0] v,
      input logic [DIM_W-1:0] u, input logic [DIM_W-1:0] it,
      input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] wr);
    return {wr, rd, it, u, v, op};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_stats(input string name);
`ifdef DECODE_STATS_EN
    check({name, "_issued_cnt"}, {16'h0, issued_cnt_o}, n_issued);
    check({name, "_illegal_cnt"}, {16'h0, illegal_cnt_o}, n_illegal);
`else
    check({name, "_issued_cnt"}, {16'h0, issued_cnt_o}, 0);
    check({name, "_illegal_cnt"}, {16'h0, illegal_cnt_o}, 0);
`endif
  endtask

  task automatic push_one(input logic [INSTR_W-1:0] instr);
    instr_valid_i = 1'b1;
    instruction_i = instr;
    tick();
    instr_valid_i = 1'b0;
  endtask

  initial begin
    //          op    v    u    it   rd      wr      iss ill mac     ev   eu   ei   ev1  eu1  ei1  erd     ewr
    vecs[0] = '{4'h1, 7'd8, 7'd4, 7'd3, 12'h010, 12'h200, 1, 0, 3'b010, 7'd8, 7'd4, 7'd3, 7'd7, 7'd3, 7'd2, 12'h010, 12'h200};
    vecs[1] = '{4'h2, 7'd1, 7'd1, 7'd1, 12'h0AB, 12'h123, 1, 0, 3'b001, 7'd1, 7'd1, 7'd1, 7'd0, 7'd0, 7'd0, 12'h0AB, 12'h000};
    vecs[2] = '{4'h3, 7'd5, 7'd6, 7'd7, 12'h003, 12'h004, 1, 0, 3'b100, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 12'h003, 12'h004};
    vecs[3] = '{4'hF, 7'd2, 7'd2, 7'd2, 12'h001, 12'h002, 0, 1, 3'b000, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 12'h000, 12'h000};
    vecs[4] = '{4'h1, 7'd0, 7'd4, 7'd3, 12'h010, 12'h200, 0, 1, 3'b000, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 12'h000, 12'h000};
    vecs[5] = '{4'h2, 7'd3, 7'd3, 7'd0, 12'h010, 12'h200, 0, 1, 3'b000, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 12'h000, 12'h000};
    vecs[6] = '{4'h0, 7'd9, 7'd9, 7'd9, 12'h055, 12'h066, 0, 0, 3'b000, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 12'h000, 12'h000};
    vecs[7] = '{4'h1, 7'd127, 7'd127, 7'd127, 12'hFFF, 12'hFFF, 1, 0, 3'b010, 7'd127, 7'd127, 7'd127, 7'd126, 7'd126, 7'd126, 12'hFFF, 12'hFFF};
    vecs[8] = '{4'h4, 7'd1, 7'd1, 7'd1, 12'h001, 12'h001, 0, 1, 3'b000, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 12'h000, 12'h000};

    // Reset state
    #2;
    check("rst_ready", instr_ready_o, 0);
    check("rst_valid", issue_valid_o, 0);
    check("rst_count", queue_count_o, 0);
    check("rst_mac", MAC_op_o, 0);
    check("rst_illegal", illegal_op_o, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    check("rst_held_ready", instr_ready_o, 0);
    rst_i = 1'b0;
    #1;
    check("rel_ready_before_edge", instr_ready_o, 0);
    tick();
    check("rel_ready_after_edge", instr_ready_o, 1);
    check_stats("rst");

    // Decode table, one instruction at a time, issue_ready_i high
    issue_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_one(pack(vecs[i].op, vecs[i].v, vecs[i].u, vecs[i].it, vecs[i].rd, vecs[i].wr));
      tick();
      check($sformatf("v%0d_valid", i), issue_valid_o, vecs[i].exp_issue);
      check($sformatf("v%0d_illegal", i), illegal_op_o, vecs[i].exp_ill);
      if (vecs[i].exp_issue) begin
        check($sformatf("v%0d_mac", i), MAC_op_o, vecs[i].mac);
        check($sformatf("v%0d_dims", i), {V_dim_o, U_dim_o, ITER_dim_o}, {vecs[i].ev, vecs[i].eu, vecs[i].ei});
        check($sformatf("v%0d_dim1", i), {V_dim1_o, U_dim1_o, ITER_dim1_o}, {vecs[i].ev1, vecs[i].eu1, vecs[i].ei1});
        check($sformatf("v%0d_rd", i), ub_addr_rd_o, vecs[i].erd);
        check($sformatf("v%0d_wr", i), ub_addr_wr_o, vecs[i].ewr);
        n_issued++;
      end
      if (vecs[i].exp_ill) n_illegal++;
      tick();
      check($sformatf("v%0d_idle_valid", i), issue_valid_o, 0);
      check($sformatf("v%0d_idle_illegal", i), illegal_op_o, 0);
    end
    check_stats("table");

    // Back-pressure: 1 held + 4 queued, then drain back-to-back in order
    issue_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push_one(pack(4'h1, 7'(i + 1), 7'd2, 7'd2, 12'(i), 12'(i)));
    check("bp_ready", instr_ready_o, 0);
    check("bp_count", queue_count_o, 4);
    check("bp_valid", issue_valid_o, 1);
    check("bp_head_v", V_dim_o, 1);
    instr_valid_i = 1'b1;
    instruction_i = pack(4'h1, 7'd99, 7'd2, 7'd2, 12'h0, 12'h0);
    tick();
    instr_valid_i = 1'b0;
    check("bp_full_reject_count", queue_count_o, 4);
    check("bp_stable_v", V_dim_o, 1);
    check("bp_stable_dim1", V_dim1_o, 0);
    issue_ready_i = 1'b1;
    instr_valid_i = 1'b1;
    #1;
    check("bp_no_bypass", instr_ready_o, 0);
    instr_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_issue%0d_valid", k), issue_valid_o, 1);
      check($sformatf("bp_issue%0d_v", k), V_dim_o, k + 1);
      tick();
      n_issued++;
    end
    check("bp_done_valid", issue_valid_o, 0);
    check("bp_done_count", queue_count_o, 0);

    // Two illegal instructions back-to-back
    push_one(pack(4'hF, 7'd1, 7'd1, 7'd1, 12'h0, 12'h0));
    push_one(pack(4'h1, 7'd0, 7'd1, 7'd1, 12'h0, 12'h0));
    check("ill_pulse1", illegal_op_o, 1);
    check("ill_valid1", issue_valid_o, 0);
    tick();
    check("ill_pulse2", illegal_op_o, 1);
    check("ill_valid2", issue_valid_o, 0);
    tick();
    check("ill_pulse_end", illegal_op_o, 0);
    n_illegal += 2;
    check_stats("ill");

    // NOP between two MATMULs gives a single-cycle bubble
    push_one(pack(4'h1, 7'd10, 7'd1, 7'd1, 12'h0, 12'h0));
    push_one(pack(4'h0, 7'd0, 7'd0, 7'd0, 12'h0, 12'h0));
    check("nop_first_valid", issue_valid_o, 1);
    check("nop_first_v", V_dim_o, 10);
    push_one(pack(4'h1, 7'd20, 7'd1, 7'd1, 12'h0, 12'h0));
    check("nop_bubble_valid", issue_valid_o, 0);
    check("nop_bubble_illegal", illegal_op_o, 0);
    tick();
    check("nop_second_valid", issue_valid_o, 1);
    check("nop_second_v", V_dim_o, 20);
    tick();
    check("nop_done_valid", issue_valid_o, 0);
    n_issued += 2;
    check_stats("nop");

`ifdef DECODE_STATS_EN
    // Saturation of the issue counter under sustained traffic
    instr_valid_i = 1'b1;
    instruction_i = pack(4'h1, 7'd1, 7'd1, 7'd1, 12'h0, 12'h0);
    for (int c = 0; c < 70000; c++) @(posedge clk_i);
    #1;
    instr_valid_i = 1'b0;
    repeat (4) tick();
    check("sat_issued", issued_cnt_o, 16'hFFFF);
    check("sat_illegal", illegal_cnt_o, n_illegal);
`endif

    // Reset mid-burst with one held and three queued
    issue_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_one(pack(4'h1, 7'd5, 7'd5, 7'd5, 12'h1, 12'h2));
    check("mid_count_before", queue_count_o, 3);
    check("mid_valid_before", issue_valid_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_valid", issue_valid_o, 0);
    check("mid_count", queue_count_o, 0);
    check("mid_ready", instr_ready_o, 0);
    check("mid_mac", MAC_op_o, 0);
    check("mid_dims", {V_dim_o, U_dim_o, ITER_dim_o, V_dim1_o}, 0);
    check("mid_addrs", {ub_addr_rd_o, ub_addr_wr_o}, 0);
    n_issued = 0;
    n_illegal = 0;
    check_stats("mid");
    tick();
    rst_i = 1'b0;
    issue_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("post_rst%0d_valid", k), issue_valid_o, 0);
    end
    check("post_rst_ready", instr_ready_o, 1);
    check("post_rst_count", queue_count_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
